serial_add_seq: RTL and testbench

Bit-serial adder sequencer: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and computes their sum one bit per clock. A single 1-bit full-adder cell and a carry flop do the arithmetic, so a wide add costs one adder cell in fabric. The block sits between an operand producer and a result consumer, and is the standard way to reuse the 1-bit add datapath for multi-bit operands in area-constrained builds.

---
 rtl/serial_add_seq_pkg.sv | 15 +
 rtl/serial_add_seq_fa_cell.sv | 17 +
 rtl/serial_add_seq.sv | 116 +++++++++++
 tb/tb_serial_add_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_seq_pkg.sv
// Shared types and reset values for the bit-serial adder sequencer.
// Holds the FSM state enum and the reset constants for the registered outputs.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam state_e STATE_RST   = IDLE;
  localparam logic   SUM_RST_BIT = 1'b0;
  localparam logic   COUT_RST    = 1'b0;

endpackage

// File: rtl/serial_add_seq_fa_cell.sv
// Purely combinational 1-bit full adder used by the serial sequencer.
// Ports: x, y, ci in; s (sum bit), co (carry out) out.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: accepts a, b, cin, then adds one bit per clock, LSB first.
// Ports: clk, rst_n; in_valid/in_ready, a, b, cin; out_valid/out_ready, sum, cout; busy.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        if (cnt_q == LAST) begin
          // Output registers load only here, so sum/cout stay stable
          // through the rest of DONE and the following IDLE.
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STATE_RST;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= {WIDTH{SUM_RST_BIT}};
      cout_q   <= COUT_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq with WIDTH=8.
// Directed cases plus random operands against an arithmetic reference.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int total;
  int bad;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction; expected result is plain integer addition.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input int gap, input int stall,
                        input bit timing, input bit scramble);
    logic [W:0] exp;
    int         n;
    int         nb;
    exp = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    for (int i = 0; i < gap; i++) step();
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    n = 0;
    nb = 0;
    while (!out_valid && n < 40) begin
      if (busy) nb++;
      step();
      n++;
    end
    chk("result_timeout", {31'd0, out_valid}, 32'd1);
    if (timing) begin
      chk("latency", n, W);
      chk("busy_cycles", nb, W);
    end
    chk("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
    chk("cout", {31'd0, cout}, {31'd0, exp[W]});
    for (int i = 0; i < stall; i++) begin
      if (scramble) begin
        a = W'($urandom);
        b = W'($urandom);
        in_valid = 1'($urandom);
      end
      step();
      chk("stall_sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
      chk("stall_cout", {31'd0, cout}, {31'd0, exp[W]});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op(8'h0F, 8'h01, 1'b0, 0, 0, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 0, 1'b1, 1'b0);
    run_op(8'h00, 8'h00, 1'b1, 1, 0, 1'b1, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 0, 5, 1'b1, 1'b1);

    // Reset asynchronously in the third RUN cycle.
    a = 8'h3C;
    b = 8'h11;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sum", {24'd0, sum}, 32'd0);
    chk("mid_rst_cout", {31'd0, cout}, 32'd0);
    step();
    chk("hold_rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("no_ghost_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op(8'h03, 8'h04, 1'b0, 0, 0, 1'b1, 1'b0);

    for (int k = 0; k < 500; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
